// File: rtl/alignement_marker_rx.sv
// 40GBASE-R receive alignment marker lock, lane ID detection and marker slot removal.
// Define PCS_40G_AM_REORDER_EN to reorder output lanes by detected lane ID once all lanes lock.
module alignement_marker_rx #(
    parameter int LANE_N    = 4,
    parameter int DATA_W    = 64,
    parameter int HEAD_W    = 2,
    parameter int AM_PERIOD = 16384
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANE_N-1:0]        block_lock_i,
    input  logic [LANE_N-1:0]        valid_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    input  logic [LANE_N*DATA_W-1:0] data_i,
    output logic [LANE_N-1:0]        valid_o,
    output logic [LANE_N*HEAD_W-1:0] head_o,
    output logic [LANE_N*DATA_W-1:0] data_o,
    output logic [LANE_N-1:0]        am_lock_o,
    output logic [LANE_N*2-1:0]      lane_id_o,
    output logic                     all_lock_o
);
    localparam int               CNT_W    = $clog2(AM_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);

    typedef enum logic [1:0] {ST_FIND, ST_COUNT, ST_LOCKED} state_t;

    // Marker bytes packed as {M6,M5,M4,M2,M1,M0}; BIP3/BIP7 excluded.
    function automatic logic [47:0] am_pattern(input logic [1:0] id);
        case (id)
            2'd0:    am_pattern = 48'hB8_89_6F_47_76_90;
            2'd1:    am_pattern = 48'h19_3B_0F_E6_C4_F0;
            2'd2:    am_pattern = 48'h64_9A_3A_9B_65_C5;
            default: am_pattern = 48'hC2_86_5D_3D_79_A2;
        endcase
    endfunction

    logic [LANE_N-1:0]   lock_next_vec;
    logic [LANE_N*2-1:0] id_next_vec;
    logic [LANE_N-1:0]   drop_vec;
    logic [LANE_N-1:0]   valid_phys;
    logic                all_lock_next;

    genvar gi;
    generate
        for (gi = 0; gi < LANE_N; gi++) begin : g_lane
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [1:0]       miss_reg, miss_next;
            logic [1:0]       id_reg, id_next;
            logic [47:0]      am_bytes;
            logic             is_am;
            logic [1:0]       am_id;
            logic             slot;
            logic             lock_now;
            logic             drop_now;

            assign am_bytes = {data_i[gi*DATA_W+32 +: 24], data_i[gi*DATA_W +: 24]};
            assign slot     = (cnt_reg == CNT_LAST);

            always_comb begin
                is_am = 1'b0;
                am_id = 2'd0;
                for (int k = 0; k < 4; k++) begin
                    if (head_i[gi*HEAD_W +: HEAD_W] == HEAD_W'(2'b10) &&
                        am_bytes == am_pattern(2'(k))) begin
                        is_am = 1'b1;
                        am_id = 2'(k);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= ST_FIND;
                    cnt_reg   <= '0;
                    miss_reg  <= '0;
                    id_reg    <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    miss_reg  <= miss_next;
                    id_reg    <= id_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                miss_next  = miss_reg;
                id_next    = id_reg;
                if (!block_lock_i[gi]) begin
                    state_next = ST_FIND;
                    cnt_next   = '0;
                    miss_next  = '0;
                end else if (valid_i[gi]) begin
                    cnt_next = slot ? '0 : cnt_reg + 1'b1;
                    case (state_reg)
                        ST_FIND: begin
                            cnt_next = '0;
                            if (is_am) begin
                                state_next = ST_COUNT;
                                id_next    = am_id;
                            end
                        end
                        ST_COUNT: begin
                            if (slot)
                                state_next = (is_am && am_id == id_reg) ? ST_LOCKED : ST_FIND;
                        end
                        ST_LOCKED: begin
                            if (slot) begin
                                if (is_am && am_id == id_reg) begin
                                    miss_next = '0;
                                end else if (miss_reg == 2'd3) begin
                                    state_next = ST_FIND;
                                    miss_next  = '0;
                                end else begin
                                    miss_next = miss_reg + 1'b1;
                                end
                            end
                        end
                        default: state_next = ST_FIND;
                    endcase
                end
            end

            always_comb begin
                lock_now = (state_reg == ST_LOCKED);
                drop_now = lock_now && valid_i[gi] && slot;
            end

            assign am_lock_o[gi]          = lock_now;
            assign drop_vec[gi]           = drop_now;
            assign lane_id_o[gi*2 +: 2]   = id_reg;
            assign lock_next_vec[gi]      = (state_next == ST_LOCKED);
            assign id_next_vec[gi*2 +: 2] = id_next;
        end
    endgenerate

    assign valid_phys = valid_i & ~drop_vec;

    // Evaluated on next-state values so all_lock_o and the lane mapping line up with am_lock_o.
    always_comb begin
        all_lock_next = &lock_next_vec;
        for (int a = 0; a < LANE_N; a++) begin
            for (int b = a + 1; b < LANE_N; b++) begin
                if (id_next_vec[a*2 +: 2] == id_next_vec[b*2 +: 2])
                    all_lock_next = 1'b0;
            end
        end
    end

    logic [LANE_N-1:0]        valid_mux;
    logic [LANE_N*HEAD_W-1:0] head_mux;
    logic [LANE_N*DATA_W-1:0] data_mux;

`ifdef PCS_40G_AM_REORDER_EN
    generate
        for (gi = 0; gi < LANE_N; gi++) begin : g_out
            logic              sel_valid;
            logic [HEAD_W-1:0] sel_head;
            logic [DATA_W-1:0] sel_data;

            always_comb begin
                sel_valid = valid_phys[gi];
                sel_head  = head_i[gi*HEAD_W +: HEAD_W];
                sel_data  = data_i[gi*DATA_W +: DATA_W];
                if (all_lock_next) begin
                    for (int p = 0; p < LANE_N; p++) begin
                        if (id_next_vec[p*2 +: 2] == 2'(gi)) begin
                            sel_valid = valid_phys[p];
                            sel_head  = head_i[p*HEAD_W +: HEAD_W];
                            sel_data  = data_i[p*DATA_W +: DATA_W];
                        end
                    end
                end
            end

            assign valid_mux[gi]                 = sel_valid;
            assign head_mux[gi*HEAD_W +: HEAD_W] = sel_head;
            assign data_mux[gi*DATA_W +: DATA_W] = sel_data;
        end
    endgenerate
`else
    assign valid_mux = valid_phys;
    assign head_mux  = head_i;
    assign data_mux  = data_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o    <= '0;
            head_o     <= '0;
            data_o     <= '0;
            all_lock_o <= 1'b0;
        end else begin
            valid_o    <= valid_mux;
            head_o     <= head_mux;
            data_o     <= data_mux;
            all_lock_o <= all_lock_next;
        end
    end
endmodule

// File: tb/tb_alignement_marker_rx.sv
// Directed bench for alignement_marker_rx: slot-level vector table plus hand sequences
// for valid gaps, block lock loss and reset. AM_PERIOD is shortened to keep runs small.
module tb_alignement_marker_rx;
    localparam int LANE_N    = 4;
    localparam int DATA_W    = 64;
    localparam int HEAD_W    = 2;
    localparam int AM_PERIOD = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [LANE_N-1:0]        block_lock_i;
    logic [LANE_N-1:0]        valid_i;
    logic [LANE_N*HEAD_W-1:0] head_i;
    logic [LANE_N*DATA_W-1:0] data_i;
    logic [LANE_N-1:0]        valid_o;
    logic [LANE_N*HEAD_W-1:0] head_o;
    logic [LANE_N*DATA_W-1:0] data_o;
    logic [LANE_N-1:0]        am_lock_o;
    logic [LANE_N*2-1:0]      lane_id_o;
    logic                     all_lock_o;

    alignement_marker_rx #(
        .LANE_N(LANE_N), .DATA_W(DATA_W), .HEAD_W(HEAD_W), .AM_PERIOD(AM_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .block_lock_i(block_lock_i), .valid_i(valid_i),
        .head_i(head_i), .data_i(data_i), .valid_o(valid_o), .head_o(head_o),
        .data_o(data_o), .am_lock_o(am_lock_o), .lane_id_o(lane_id_o), .all_lock_o(all_lock_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Lane codes: 0-3 marker of that ID, 4-7 marker of ID (code-4) with M1 corrupted, 8 filler.
    typedef struct {
        bit          do_reset;
        int          gap;
        logic [15:0] code;
        logic [3:0]  exp_am;
        logic [7:0]  exp_id;
        logic        exp_all;
        bit          chk_valid;
        logic [3:0]  exp_valid;
        bit          chk_data;
    } vec_t;

    vec_t vecs [17];
    logic [DATA_W-1:0] applied [LANE_N];

    function automatic logic [63:0] am_data(input logic [1:0] id, input bit corrupt);
        logic [63:0] d;
        case (id)
            2'd0:    d = 64'h5A_B8_89_6F_A5_47_76_90;
            2'd1:    d = 64'h5A_19_3B_0F_A5_E6_C4_F0;
            2'd2:    d = 64'h5A_64_9A_3A_A5_9B_65_C5;
            default: d = 64'h5A_C2_86_5D_A5_3D_79_A2;
        endcase
        if (corrupt) d[15:8] = ~d[15:8];
        return d;
    endfunction

    task automatic set_lane(input int p, input logic [3:0] code);
        logic [DATA_W-1:0] d;
        if (code < 4'd8) begin
            d = am_data(code[1:0], code[2]);
            head_i[p*HEAD_W +: HEAD_W] = 2'b10;
        end else begin
            d = {$urandom, $urandom};
            head_i[p*HEAD_W +: HEAD_W] = 2'b01;
        end
        data_i[p*DATA_W +: DATA_W] = d;
        applied[p] = d;
    endtask

    task automatic set_all(input logic [15:0] code);
        for (int p = 0; p < LANE_N; p++) set_lane(p, code[p*4 +: 4]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = '0;
        set_all(16'h8888);
        tick();
        reset = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [DATA_W-1:0] exp_d;
        if (v.do_reset) do_reset();
        for (int c = 0; c < v.gap; c++) begin
            set_all(16'h8888);
            valid_i = '1;
            tick();
        end
        set_all(v.code);
        valid_i = '1;
        tick();
        $display("[TB] vec %0d code=%h am=%h id=%h all=%b valid=%h",
                 idx, v.code, am_lock_o, lane_id_o, all_lock_o, valid_o);
        check($sformatf("vec%0d am_lock", idx), 256'(am_lock_o), 256'(v.exp_am));
        check($sformatf("vec%0d lane_id", idx), 256'(lane_id_o), 256'(v.exp_id));
        check($sformatf("vec%0d all_lock", idx), 256'(all_lock_o), 256'(v.exp_all));
        if (v.chk_valid)
            check($sformatf("vec%0d valid_o", idx), 256'(valid_o), 256'(v.exp_valid));
        if (v.chk_data) begin
            exp_d = applied[0];
`ifdef PCS_40G_AM_REORDER_EN
            if (v.exp_all)
                for (int p = 0; p < LANE_N; p++)
                    if (v.exp_id[p*2 +: 2] == 2'd0) exp_d = applied[p];
`endif
            check($sformatf("vec%0d data_o lane0", idx), 256'(data_o[DATA_W-1:0]), 256'(exp_d));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          rst  gap  code      am     id     all   chkv  valid  chkd
        vecs[0]  = '{1'b1, 3,  16'h3210, 4'h0, 8'hE4, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[1]  = '{1'b0, 15, 16'h3210, 4'hF, 8'hE4, 1'b1, 1'b0, 4'hF, 1'b0};
        vecs[2]  = '{1'b0, 15, 16'h3210, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[3]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[4]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[5]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[6]  = '{1'b0, 15, 16'h3210, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[7]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[8]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[9]  = '{1'b0, 15, 16'h3610, 4'hF, 8'hE4, 1'b1, 1'b1, 4'h0, 1'b0};
        vecs[10] = '{1'b0, 15, 16'h3610, 4'hB, 8'hE4, 1'b0, 1'b1, 4'h0, 1'b0};
        vecs[11] = '{1'b1, 3,  16'h0123, 4'h0, 8'h1B, 1'b0, 1'b1, 4'hF, 1'b1};
        vecs[12] = '{1'b0, 15, 16'h0123, 4'hF, 8'h1B, 1'b1, 1'b0, 4'hF, 1'b1};
        vecs[13] = '{1'b1, 3,  16'h3110, 4'h0, 8'hD4, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[14] = '{1'b0, 15, 16'h3110, 4'hF, 8'hD4, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[15] = '{1'b1, 3,  16'h3211, 4'h0, 8'hE5, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[16] = '{1'b0, 15, 16'h3213, 4'hE, 8'hE5, 1'b0, 1'b0, 4'hF, 1'b0};

        block_lock_i = '1;
        reset        = 1'b1;
        valid_i      = '1;
        set_all(16'h3210);
        tick();
        tick();
        $display("[TB] reset: valid=%h am=%h id=%h all=%b", valid_o, am_lock_o, lane_id_o, all_lock_o);
        check("reset valid_o", 256'(valid_o), 256'(0));
        check("reset am_lock", 256'(am_lock_o), 256'(0));
        check("reset lane_id", 256'(lane_id_o), 256'(0));
        check("reset all_lock", 256'(all_lock_o), 256'(0));
        check("reset head_o", 256'(head_o), 256'(0));
        check("reset data_o", data_o, 256'(0));
        reset = 1'b0;

        // A marker seen while valid_i is low must not be captured.
        set_all(16'h3333);
        valid_i = '0;
        tick();
        $display("[TB] invalid marker: id=%h valid=%h", lane_id_o, valid_o);
        check("invalid match lane_id", 256'(lane_id_o), 256'(0));
        check("invalid match valid_o", 256'(valid_o), 256'(0));

        set_all(16'h8888);
        valid_i = '1;
        begin
            logic [LANE_N*HEAD_W-1:0] h_exp;
            logic [LANE_N*DATA_W-1:0] d_exp;
            h_exp = head_i;
            d_exp = data_i;
            tick();
            $display("[TB] passthrough: head=%h", head_o);
            check("passthrough head_o", 256'(head_o), 256'(h_exp));
            check("passthrough data_o", data_o, d_exp);
            check("passthrough valid_o", 256'(valid_o), 256'(4'hF));
        end

        for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

        // Valid gaps inside COUNT must not advance the block counter.
        do_reset();
        set_all(16'h3210);
        valid_i = '1;
        tick();
        check("gap capture lane_id", 256'(lane_id_o), 256'(8'hE4));
        for (int c = 0; c < 20; c++) begin
            set_all(16'h8888);
            valid_i = (c >= 5 && c < 10) ? 4'h0 : 4'hF;
            tick();
            if (c == 5) check("gap valid_o low", 256'(valid_o), 256'(0));
        end
        set_all(16'h3210);
        valid_i = '1;
        tick();
        $display("[TB] gap lock: am=%h all=%b", am_lock_o, all_lock_o);
        check("gap lock am_lock", 256'(am_lock_o), 256'(4'hF));
        check("gap lock all_lock", 256'(all_lock_o), 256'(1));

        for (int c = 0; c < 3; c++) begin
            set_all(16'h8888);
            tick();
        end
        block_lock_i = 4'b1101;
        set_all(16'h8888);
        tick();
        $display("[TB] block lock drop: am=%h all=%b", am_lock_o, all_lock_o);
        check("lock drop am_lock", 256'(am_lock_o), 256'(4'hD));
        check("lock drop all_lock", 256'(all_lock_o), 256'(0));
        block_lock_i = '1;
        set_all(16'h8888);
        tick();
        check("lock drop held am_lock", 256'(am_lock_o), 256'(4'hD));

        reset = 1'b1;
        set_all(16'h3210);
        tick();
        $display("[TB] reset pulse: valid=%h am=%h id=%h all=%b", valid_o, am_lock_o, lane_id_o, all_lock_o);
        check("pulse valid_o", 256'(valid_o), 256'(0));
        check("pulse am_lock", 256'(am_lock_o), 256'(0));
        check("pulse lane_id", 256'(lane_id_o), 256'(0));
        check("pulse all_lock", 256'(all_lock_o), 256'(0));
        check("pulse head_o", 256'(head_o), 256'(0));
        check("pulse data_o", data_o, 256'(0));
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alignement_marker_rx.md
ALIGNEMENT_MARKER_RX -- requirements
Module: alignement_marker_rx

Interface
REQ-001 The block SHALL expose parameter LANE_N, default 4, number of PCS lanes.
REQ-002 The block SHALL expose parameter DATA_W, default 64, block payload width per lane.
REQ-003 The block SHALL expose parameter HEAD_W, default 2, sync header width per lane.
REQ-004 The block SHALL expose parameter AM_PERIOD, default 16384, blocks per lane between markers, including the marker block itself.
REQ-005 The block SHALL have port clk  input  1  sole clock, all logic on the rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port block_lock_i  input  LANE_N  per-lane 66b block lock from the block sync stage.
REQ-008 The block SHALL have port valid_i  input  LANE_N  per-lane block valid, low on gearbox slip cycles.
REQ-009 The block SHALL have port head_i  input  LANE_N*HEAD_W  per-lane sync header.
REQ-010 The block SHALL have port data_i  input  LANE_N*DATA_W  per-lane scrambled block payload, marker byte M0 in bits [7:0].
REQ-011 The block SHALL have port valid_o  output  LANE_N  per-lane block valid, low on removed marker slots.
REQ-012 The block SHALL have port head_o  output  LANE_N*HEAD_W  per-lane header.
REQ-013 The block SHALL have port data_o  output  LANE_N*DATA_W  per-lane payload.
REQ-014 The block SHALL have port am_lock_o  output  LANE_N  per-lane alignment marker lock.
REQ-015 The block SHALL have port lane_id_o  output  LANE_N*2  logical lane number detected on each physical lane.
REQ-016 The block SHALL have port all_lock_o  output  1  all lanes locked with distinct lane IDs.

Function
REQ-017 A marker match SHALL mean head = 2'b10 and bytes M0,M1,M2,M4,M5,M6 equal a lane's 40GBASE-R values: lane0 90/76/47/6F/89/B8, lane1 F0/C4/E6/0F/3B/19, lane2 C5/65/9B/3A/9A/64, lane3 A2/79/3D/5D/86/C2. BIP3/BIP7 are ignored.
REQ-018 Each lane SHALL run an independent FSM with states FIND, COUNT, LOCKED. Only cycles with valid_i=1 advance it.
REQ-019 FIND: on a match, the FSM SHALL capture the lane ID, clear the block counter and go to COUNT.
REQ-020 COUNT: the counter SHALL increment per valid block. At the block AM_PERIOD after the capture: a match with the same ID SHALL go to LOCKED; any other block SHALL return to FIND.
REQ-021 LOCKED: at each expected slot, a same-ID match SHALL clear the miss counter and anything else SHALL increment it. The 4th consecutive miss SHALL go to FIND.
REQ-022 block_lock_i=0 SHALL force FIND and clear both counters the next cycle, from any state.
REQ-023 The block counter SHALL wrap from AM_PERIOD-1 to 0 on the marker slot. The 2-bit miss counter SHALL saturate at 3 until the transition.
REQ-024 am_lock_o SHALL be 1 exactly while in LOCKED. lane_id_o SHALL hold the last captured ID and be 0 after reset.
REQ-025 valid_o SHALL be 0 on a locked lane's expected marker slot, matched or not. Otherwise valid_o SHALL equal the delayed valid_i.
REQ-026 Datapath latency SHALL be 1 cycle, registered. head_o/data_o SHALL pass unmodified.
REQ-027 all_lock_o SHALL be 1 when all am_lock_o=1 and the lane IDs are pairwise distinct, else 0. It SHALL be registered with the same 1-cycle latency.
REQ-028 A match in FIND while valid_i=0 SHALL be ignored.

Reset
REQ-029 Under reset, all FSMs SHALL be FIND with counters 0. valid_o, am_lock_o, lane_id_o, all_lock_o SHALL be 0. head_o and data_o SHALL be 0.
REQ-030 Reset asserted mid-lock SHALL drop all locks on the next edge. There SHALL be no partial state retention.

Configuration
REQ-031 Macro PCS_40G_AM_REORDER_EN defined: while all_lock_o=1, output lane n SHALL carry the physical lane whose lane_id_o equals n, at the same latency.
REQ-032 Macro PCS_40G_AM_REORDER_EN defined, all_lock_o=0: output lanes SHALL be in physical order.
REQ-033 Macro PCS_40G_AM_REORDER_EN undefined: outputs SHALL always be in physical order and the reorder mux SHALL not exist.

Verification
REQ-034 Markers on all lanes, in order, every 16384 valid blocks -> am_lock_o=4'hF one cycle after the 2nd marker; lane_id_o=8'hE4; all_lock_o=1; valid_o=0 on every marker slot.
REQ-035 Locked lane 2, corrupt M1 at 3 consecutive slots then a correct one -> lock held, miss counter cleared. Corrupt 4 consecutive slots -> am_lock_o[2]=0 after the 4th.
REQ-036 Lane 0 carries a lane1 marker at capture and a lane3 marker at the 2nd slot -> FSM returns to FIND, am_lock_o[0]=0.
REQ-037 Physical lanes carry IDs 3,2,1,0 -> lane_id_o=8'h1B. With PCS_40G_AM_REORDER_EN, data_o lane 0 equals data_i lane 3. Without it, the output is unchanged.
REQ-038 Two lanes carry ID 1 -> am_lock_o=4'hF and all_lock_o=0.
REQ-039 valid_i=0 for 5 cycles inside COUNT, then drop block_lock_i[1] while locked -> marker still found at valid block 16384; lane 1 is in FIND next cycle; reset pulse -> all outputs 0.
